// File: rtl/box_drawer.sv
// Box drawer: streams a BOX_W x BOX_H rectangle of pixels, one per cycle, to a VGA-style write port.
// Optional feature macro BOX_OUTLINE_EN adds an 'outline' input that writes only the box perimeter.
module box_drawer #(
    parameter int BOX_W       = 4,
    parameter int BOX_H       = 4,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int COLOUR_BITS = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   erase,
    input  logic [7:0]             x_in,
    input  logic [6:0]             y_in,
    input  logic [COLOUR_BITS-1:0] colour_in,
    input  logic [COLOUR_BITS-1:0] bg_colour,
`ifdef BOX_OUTLINE_EN
    input  logic                   outline,
`endif
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   wren,
    output logic                   busy,
    output logic                   finish,
    output logic [2:0]             curr
);

    localparam logic [3:0] COL_LAST     = 4'(BOX_W - 1);
    localparam logic [3:0] ROW_LAST     = 4'(BOX_H - 1);
    localparam logic [8:0] SCREEN_W_LIM = 9'(SCREEN_W);
    localparam logic [7:0] SCREEN_H_LIM = 8'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DRAW = 3'd2,
        S_DONE = 3'd3
    } state_t;

    // Coordinates are widened by one bit so off-screen pixels clip instead of wrapping.
    function automatic logic in_screen(input logic [8:0] px, input logic [7:0] py);
        return (px < SCREEN_W_LIM) && (py < SCREEN_H_LIM);
    endfunction

`ifdef BOX_OUTLINE_EN
    function automatic logic on_perimeter(input logic [3:0] col, input logic [3:0] row);
        return (col == 4'd0) || (col == COL_LAST) || (row == 4'd0) || (row == ROW_LAST);
    endfunction
`endif

    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             base_x_q;
    logic [6:0]             base_y_q;
    logic [COLOUR_BITS-1:0] draw_colour_q;
`ifdef BOX_OUTLINE_EN
    logic                   outline_q;
`endif
    logic [3:0]             col_q;
    logic [3:0]             col_d;
    logic [3:0]             row_q;
    logic [3:0]             row_d;

    logic [7:0]             x_q;
    logic [7:0]             x_d;
    logic [6:0]             y_q;
    logic [6:0]             y_d;
    logic [COLOUR_BITS-1:0] colour_q;
    logic [COLOUR_BITS-1:0] colour_d;
    logic                   wren_q;
    logic                   wren_d;
    logic                   busy_q;
    logic                   busy_d;
    logic                   finish_q;
    logic                   finish_d;

    logic                   capture_s;
    logic                   last_px_s;
    logic [8:0]             px_x_s;
    logic [7:0]             px_y_s;
    logic                   px_write_s;

    assign capture_s = (state_q == S_IDLE) && start;
    assign last_px_s = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign px_x_s    = {1'b0, base_x_q} + {5'b0_0000, col_q};
    assign px_y_s    = {1'b0, base_y_q} + {4'b0000, row_q};

    // Pixel write qualifier: on-screen, and on the perimeter when outlining.
    always_comb begin
        px_write_s = in_screen(px_x_s, px_y_s);
`ifdef BOX_OUTLINE_EN
        if (outline_q) begin
            px_write_s = px_write_s && on_perimeter(col_q, row_q);
        end else begin
            px_write_s = px_write_s;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: state_d = S_DRAW;
            S_DRAW: begin
                if (last_px_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Column/row scan counters: cleared in LOAD, row-major advance in DRAW.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        case (state_q)
            S_LOAD: begin
                col_d = 4'd0;
                row_d = 4'd0;
            end
            S_DRAW: begin
                if (col_q == COL_LAST) begin
                    col_d = 4'd0;
                    row_d = row_q + 4'd1;
                end else begin
                    col_d = col_q + 4'd1;
                    row_d = row_q;
                end
            end
            default: begin
                col_d = col_q;
                row_d = row_q;
            end
        endcase
    end

    // Request operands are captured on the accepting edge so later input changes cannot disturb the box.
    always_ff @(posedge clk) begin
        if (resetn) begin
            base_x_q      <= 8'd0;
            base_y_q      <= 7'd0;
            draw_colour_q <= {COLOUR_BITS{1'b0}};
`ifdef BOX_OUTLINE_EN
            outline_q     <= 1'b0;
`endif
            col_q         <= 4'd0;
            row_q         <= 4'd0;
        end else begin
            if (capture_s) begin
                base_x_q      <= x_in;
                base_y_q      <= y_in;
                draw_colour_q <= erase ? bg_colour : colour_in;
`ifdef BOX_OUTLINE_EN
                outline_q     <= outline;
`endif
            end
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Output decode; results are registered, so pixels and finish trail the state by one cycle.
    always_comb begin
        x_d      = 8'd0;
        y_d      = 7'd0;
        colour_d = {COLOUR_BITS{1'b0}};
        wren_d   = 1'b0;
        finish_d = 1'b0;
        busy_d   = (state_d == S_LOAD) || (state_d == S_DRAW);
        case (state_q)
            S_DRAW: begin
                x_d      = px_x_s[7:0];
                y_d      = px_y_s[6:0];
                colour_d = draw_colour_q;
                wren_d   = px_write_s;
            end
            S_DONE:  finish_d = 1'b1;
            default: finish_d = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (resetn) begin
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= {COLOUR_BITS{1'b0}};
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            wren_q   <= wren_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign wren   = wren_q;
    assign busy   = busy_q;
    assign finish = finish_q;
    assign curr   = state_q;

endmodule

// File: doc/box_drawer.md
BOX_DRAWER -- requirements
Module: box_drawer

Interface
- REQ-001: Parameter BOX_W, default 4, box width in pixels (1..16).
- REQ-002: Parameter BOX_H, default 4, box height in pixels (1..16).
- REQ-003: Parameter SCREEN_W, default 160, visible columns; SCREEN_H, default 120, visible rows.
- REQ-004: Parameter COLOUR_BITS, default 3, colour width.
- REQ-005: clk  input  1  system clock, all logic on rising edge.
- REQ-006: resetn  input  1  synchronous, active-high reset; despite the name, 1 = reset.
- REQ-007: start  input  1  request a box draw; sampled only in IDLE.
- REQ-008: erase  input  1  when 1, the draw uses bg_colour instead of colour_in; sampled with start.
- REQ-009: x_in  input  8  top-left column; y_in  input  7  top-left row; sampled with start.
- REQ-010: colour_in, bg_colour  input  COLOUR_BITS  foreground and background colours; sampled with start.
- REQ-011: x  output  8, y  output  7, colour  output  COLOUR_BITS  pixel to write.
- REQ-012: wren  output  1  VGA write enable, valid with x/y/colour the same cycle.
- REQ-013: busy  output  1  high in LOAD and DRAW.
- REQ-014: finish  output  1  one-cycle pulse when a box completes.
- REQ-015: curr  output  3  current FSM state encoding, for LED debug.

Function
- REQ-016: FSM states: IDLE=0, LOAD=1, DRAW=2, DONE=3; curr reflects the state register.
- REQ-017: IDLE->LOAD when start=1; otherwise stay in IDLE.
- REQ-018: LOAD latches the base x/y, erase, and the selected colour, clears the column/row counters, and then goes to DRAW next cycle.
- REQ-019: DRAW emits one pixel per cycle in row-major order: col 0..BOX_W-1 inner, row 0..BOX_H-1 outer; x=base_x+col, y=base_y+row.
- REQ-020: DRAW lasts exactly BOX_W*BOX_H cycles, then goes to DONE; DONE asserts finish for one cycle and returns to IDLE.
- REQ-021: First wren occurs 2 cycles after the start-sampling edge; start-to-finish latency is BOX_W*BOX_H+2 cycles.
- REQ-022: Clipping: a pixel with base_x+col >= SCREEN_W or base_y+row >= SCREEN_H gets wren=0. It still consumes its cycle, and its coordinate adders are 9-bit and 8-bit wide (no wrap-around).
- REQ-023: start while busy or in DONE is ignored (not queued).
- REQ-024: start held high continuously starts a new box one cycle after DONE (back-to-back period BOX_W*BOX_H+3).
- REQ-025: Input changes during LOAD/DRAW/DONE do not affect the box in progress.
- REQ-026: wren=0 in IDLE, LOAD and DONE.

Reset
- REQ-027: resetn=1 at a clock edge forces IDLE, counters 0, and x=0, y=0, colour=0, wren=0, busy=0, finish=0, curr=0.
- REQ-028: Reset mid-DRAW aborts the box: no further wren and no finish pulse.
- REQ-029: Reset dominates a simultaneous start.

Configuration
- REQ-030: Macro BOX_OUTLINE_EN. When defined, the module adds input outline (1 bit, sampled with start). When outline=1, wren is asserted only for perimeter pixels (row 0, row BOX_H-1, col 0, col BOX_W-1), with clipping still applied. Cycle count is unchanged.
- REQ-031: Without BOX_OUTLINE_EN, the outline port is absent and every unclipped pixel is written.

Verification
- REQ-032: Reset, then start=1, x_in=10, y_in=20, colour_in=5, BOX 4x4: 16 wren pulses, (10,20) to (13,23) row-major, colour=5, finish 18 cycles after start.
- REQ-033: erase=1, bg_colour=0, same box: 16 writes with colour=0.
- REQ-034: x_in=158, y_in=118, 4x4: exactly 4 wren pulses at (158..159, 118..119); busy still lasts 17 cycles; finish still pulses.
- REQ-035: Assert resetn after the 5th pixel: wren=0 next cycle, curr=0, no finish; a new start then draws a full 16 pixels.
- REQ-036: Second start pulse during DRAW: ignored, only one finish; start held high gives finish pulses 19 cycles apart.
- REQ-037: With BOX_OUTLINE_EN and outline=1, 4x4 at (0,0): 12 writes; interior pixels (1..2,1..2) not written; finish timing unchanged.
